// File: rtl/mod8_tff_counter.sv
// Synchronous mod-8 up counter built from three T-type state bits.
// Tc flags the cycle before wrap (count at 7 while enabled).
module mod8_tff_counter (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  output logic [2:0] Out,
  output logic       Tc
);

  logic q0_q, q1_q, q2_q;
  logic q0_d, q1_d, q2_d;
  logic t0, t1, t2;

  // Toggle terms of a synchronous binary counter; every bit shares Clk.
  always_comb begin
    t0 = 1'b1;
    t1 = q0_q;
    t2 = q0_q & q1_q;
  end

  always_comb begin
    q0_d = q0_q ^ (En & t0);
    q1_d = q1_q ^ (En & t1);
    q2_d = q2_q ^ (En & t2);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q0_q <= 1'b0;
      q1_q <= 1'b0;
      q2_q <= 1'b0;
    end else begin
      q0_q <= q0_d;
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

  assign Out = {q2_q, q1_q, q0_q};
  assign Tc  = En & q0_q & q1_q & q2_q;

endmodule

// File: tb/tb_mod8_tff_counter.sv
// Directed bench for mod8_tff_counter: a reference count model feeds an
// expected-value queue that is popped and compared after each clock edge.
module tb_mod8_tff_counter;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [2:0] Out;
  logic       Tc;

  int total;
  int bad;

  logic [2:0] exp_q[$];
  logic [2:0] model_cnt;
  logic       model_known;

  mod8_tff_counter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (En),
    .Out   (Out),
    .Tc    (Tc)
  );

  // clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle: set inputs away from the edge, check Tc combinationally,
  // advance the model, then compare Out and Tc after the rising edge.
  task automatic tick(input logic rst, input logic en, input string tag);
    logic [2:0] exp_v;
    @(negedge Clk);
    Reset = rst;
    En    = en;
    #1;
    if (model_known)
      check({tag, "_tc_pre"}, {2'b00, Tc}, {2'b00, (model_cnt == 3'd7) && en});
    if (rst) model_cnt = 3'd0;
    else if (en) model_cnt = model_cnt + 3'd1;
    model_known = 1'b1;
    exp_q.push_back(model_cnt);
    @(posedge Clk);
    #1;
    exp_v = exp_q.pop_front();
    check({tag, "_out"}, Out, exp_v);
    check({tag, "_tc_post"}, {2'b00, Tc}, {2'b00, (exp_v == 3'd7) && en && !rst});
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_cnt = 3'd0;
    model_known = 1'b0;
    Reset = 1'b0;
    En = 1'b0;

    // reset with enable asserted: reset wins
    tick(1'b1, 1'b1, "reset_en");

    // full cycle including wrap 7 -> 0
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, "count8");

    // hold at 3 for five edges, then resume
    tick(1'b1, 1'b0, "rst_a");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, "to3");
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, "hold3");
    tick(1'b0, 1'b1, "resume4");

    // mid-count reset at 5
    tick(1'b0, 1'b1, "to5");
    check("at5", Out, 3'd5);
    tick(1'b1, 1'b1, "midreset");
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, "after_rst");
    check("at2", Out, 3'd2);

    // terminal count held with En low, then enabled
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, "to7");
    check("at7", Out, 3'd7);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "hold7");
    tick(1'b0, 1'b1, "wrap7");
    check("wrapped", Out, 3'd0);

    // reset pulse entirely between edges must be ignored
    tick(1'b0, 1'b1, "pre_glitch");
    @(negedge Clk);
    En = 1'b0;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("glitch_reset", Out, model_cnt);

    // free run from reset
    tick(1'b1, 1'b0, "rst_free");
    for (int n = 1; n <= 20; n++) begin
      tick(1'b0, 1'b1, "free");
      check("free_mod8", Out, 3'(n % 8));
    end

    if (exp_q.size() != 0) begin
      bad++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
